// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_decoder
// Description : Receive side of a multiplexed seven-segment display bus.
//               Follows the anode scan and waits for each digit to settle.
//               Decodes segment patterns back to hex nibbles and publishes
//               one coherent multi-digit value per completed scan frame.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_decoder #(
  parameter int         SETTLE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] DIGIT_MASK     = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sseg,
  input  logic [7:0]  AN,
  input  logic        DP,
  output logic [31:0] value,
  output logic [7:0]  blank,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        multi_an_err,
  output logic        scan_stall
);

  localparam int C_STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam int C_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_STAB_W-1:0] C_STAB_MAX  = C_STAB_W'(SETTLE_CYCLES);
  localparam logic [C_STAB_W-1:0] C_STAB_ONE  = C_STAB_W'(1);
  localparam logic [C_TO_W-1:0]   C_TO_MAX    = C_TO_W'(TIMEOUT_CYCLES);
  localparam logic [6:0]          C_SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

  // Input sample S and previous sample P
  logic [7:0] s_an_q,  s_an_d,  p_an_q,  p_an_d;
  logic [6:0] s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic       s_dp_q,  s_dp_d,  p_dp_q,  p_dp_d;

  logic [C_STAB_W-1:0] stab_q, stab_d;
  logic [C_TO_W-1:0]   to_cnt_q, to_cnt_d;
  state_t              state_q, state_d;

  // Per-slot capture storage and frame progress
  logic [31:0] slot_nib_q, slot_nib_d;
  logic [7:0]  slot_blank_q, slot_blank_d;
  logic [7:0]  slot_dp_q, slot_dp_d;
  logic [7:0]  seen_q, seen_d;

  // Registered outputs
  logic [31:0] value_q, value_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  dp_q, dp_d;
  logic        frame_valid_q, frame_valid_d;
  logic        bad_pattern_q, bad_pattern_d;
  logic        multi_an_err_q, multi_an_err_d;
  logic        scan_stall_q, scan_stall_d;

  // Combinational helpers
  logic                w_s_eq_p;
  logic [C_STAB_W-1:0] w_stab;
  logic                w_settled;
  logic                w_any_low;
  logic                w_one_hot;
  logic [2:0]          w_idx;
  logic [4:0]          w_dec;
  logic                w_eval;
  logic                w_capture;
  logic [3:0]          w_cap_nib;
  logic                w_cap_blank;
  logic [31:0]         w_value_masked;

  // Segment pattern (active-low gfedcba) to {known, nibble}
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Only masked slots contribute nibbles to the published value
  for (genvar gi = 0; gi < 8; gi++) begin : g_value_mask
    assign w_value_masked[gi*4 +: 4] = DIGIT_MASK[gi] ? slot_nib_q[gi*4 +: 4] : 4'h0;
  end

  // Sample stability, anode analysis and the decision to evaluate this sample
  always_comb begin
    w_s_eq_p  = (s_an_q == p_an_q) && (s_seg_q == p_seg_q) && (s_dp_q == p_dp_q);
    if (!w_s_eq_p) begin
      w_stab = C_STAB_ONE;
    end else if (stab_q == C_STAB_MAX) begin
      w_stab = C_STAB_MAX;
    end else begin
      w_stab = stab_q + C_STAB_ONE;
    end
    w_settled = (w_stab == C_STAB_MAX);
    w_any_low = |(~s_an_q);
    w_one_hot = $onehot(~s_an_q);
    w_idx     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!s_an_q[i]) w_idx = 3'(i);
    end
    w_dec = f_decode(s_seg_q);
    // A settled sample is evaluated once; a held sample after capture is not
    // re-evaluated, and an idle bus with no anode low is simply ignored.
    w_eval = w_settled
           && !((state_q == ST_CAPTURED) && w_s_eq_p)
           && !((state_q == ST_IDLE) && !w_any_low);
  end

  // Next-state logic for FSM, slots, frame publication and timeout
  always_comb begin
    s_an_d         = AN;
    s_seg_d        = sseg;
    s_dp_d         = DP;
    p_an_d         = s_an_q;
    p_seg_d        = s_seg_q;
    p_dp_d         = s_dp_q;
    stab_d         = w_stab;
    state_d        = state_q;
    slot_nib_d     = slot_nib_q;
    slot_blank_d   = slot_blank_q;
    slot_dp_d      = slot_dp_q;
    seen_d         = seen_q;
    value_d        = value_q;
    blank_d        = blank_q;
    dp_d           = dp_q;
    frame_valid_d  = 1'b0;
    bad_pattern_d  = 1'b0;
    multi_an_err_d = 1'b0;
    w_capture      = 1'b0;
    w_cap_nib      = 4'h0;
    w_cap_blank    = 1'b0;
    to_cnt_d       = (to_cnt_q == C_TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

    // Publish the frame one cycle after every masked slot has been seen
    if ((seen_q & DIGIT_MASK) == DIGIT_MASK) begin
      frame_valid_d = 1'b1;
      value_d       = w_value_masked;
      blank_d       = slot_blank_q & DIGIT_MASK;
      dp_d          = slot_dp_q & DIGIT_MASK;
      seen_d        = 8'h00;
    end

    if (w_eval) begin
      if (!w_any_low) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_CAPTURED;
        if (!w_one_hot) begin
          multi_an_err_d = 1'b1;
        end else if (s_seg_q == C_SEG_BLANK) begin
          w_capture   = 1'b1;
          w_cap_blank = 1'b1;
        end else if (w_dec[4]) begin
          w_capture = 1'b1;
          w_cap_nib = w_dec[3:0];
        end else begin
          bad_pattern_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE:     state_d = w_any_low ? ST_SETTLING : ST_IDLE;
        ST_SETTLING: state_d = ST_SETTLING;
        ST_CAPTURED: if (!w_s_eq_p) state_d = w_any_low ? ST_SETTLING : ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    // Capture lands after any frame clear so it counts toward the next frame
    if (w_capture) begin
      slot_nib_d[{w_idx, 2'b00} +: 4] = w_cap_nib;
      slot_blank_d[w_idx]             = w_cap_blank;
      slot_dp_d[w_idx]                = ~s_dp_q;
      seen_d[w_idx]                   = 1'b1;
      to_cnt_d                        = '0;
    end

    scan_stall_d = (to_cnt_d == C_TO_MAX);
  end

  // All state registers with synchronous reset to an idle bus view
  always_ff @(posedge clk) begin
    if (rst) begin
      s_an_q         <= 8'hFF;
      s_seg_q        <= C_SEG_BLANK;
      s_dp_q         <= 1'b1;
      p_an_q         <= 8'hFF;
      p_seg_q        <= C_SEG_BLANK;
      p_dp_q         <= 1'b1;
      stab_q         <= '0;
      to_cnt_q       <= '0;
      state_q        <= ST_IDLE;
      slot_nib_q     <= 32'h0;
      slot_blank_q   <= 8'h00;
      slot_dp_q      <= 8'h00;
      seen_q         <= 8'h00;
      value_q        <= 32'h0;
      blank_q        <= 8'h00;
      dp_q           <= 8'h00;
      frame_valid_q  <= 1'b0;
      bad_pattern_q  <= 1'b0;
      multi_an_err_q <= 1'b0;
      scan_stall_q   <= 1'b0;
    end else begin
      s_an_q         <= s_an_d;
      s_seg_q        <= s_seg_d;
      s_dp_q         <= s_dp_d;
      p_an_q         <= p_an_d;
      p_seg_q        <= p_seg_d;
      p_dp_q         <= p_dp_d;
      stab_q         <= stab_d;
      to_cnt_q       <= to_cnt_d;
      state_q        <= state_d;
      slot_nib_q     <= slot_nib_d;
      slot_blank_q   <= slot_blank_d;
      slot_dp_q      <= slot_dp_d;
      seen_q         <= seen_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      dp_q           <= dp_d;
      frame_valid_q  <= frame_valid_d;
      bad_pattern_q  <= bad_pattern_d;
      multi_an_err_q <= multi_an_err_d;
      scan_stall_q   <= scan_stall_d;
    end
  end

  assign value        = value_q;
  assign blank        = blank_q;
  assign dp           = dp_q;
  assign frame_valid  = frame_valid_q;
  assign bad_pattern  = bad_pattern_q;
  assign multi_an_err = multi_an_err_q;
  assign scan_stall   = scan_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_decoder
// Description : Directed self-checking bench for sseg_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  sseg;
  logic [7:0]  AN;
  logic        DP;
  logic [31:0] value;
  logic [7:0]  blank;
  logic [7:0]  dp;
  logic        frame_valid;
  logic        bad_pattern;
  logic        multi_an_err;
  logic        scan_stall;

  int total = 0;
  int bad   = 0;

  // Cumulative pulse counters, sampled mid-cycle
  int fv_cnt = 0;
  int bp_cnt = 0;
  int ma_cnt = 0;

  always #5 clk = ~clk;

  sseg_scan_decoder #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(50),
    .DIGIT_MASK    (8'h03)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sseg        (sseg),
    .AN          (AN),
    .DP          (DP),
    .value       (value),
    .blank       (blank),
    .dp          (dp),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .multi_an_err(multi_an_err),
    .scan_stall  (scan_stall)
  );

  always @(negedge clk) begin
    if (frame_valid)  fv_cnt <= fv_cnt + 1;
    if (bad_pattern)  bp_cnt <= bp_cnt + 1;
    if (multi_an_err) ma_cnt <= ma_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dpn, input int n);
    AN   = an;
    sseg = seg;
    DP   = dpn;
    tick(n);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    AN   = 8'hFF;
    sseg = 7'h7F;
    DP   = 1'b1;
    tick(2);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (value !== 32'h0) begin bad++; $display("FAIL reset_value: got %h want %h", value, 32'h0); end
    total++; if (blank !== 8'h00) begin bad++; $display("FAIL reset_blank: got %h want %h", blank, 8'h00); end
    total++; if (dp !== 8'h00) begin bad++; $display("FAIL reset_dp: got %h want %h", dp, 8'h00); end
    total++; if ({frame_valid, bad_pattern, multi_an_err, scan_stall} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want %b", {frame_valid, bad_pattern, multi_an_err, scan_stall}, 4'b0000);
    end
  endtask

  task automatic test_basic_frame();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    drive(8'hFE, 7'h79, 1'b1, 6);
    AN = 8'hFD; sseg = 7'h24;
    tick(5);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_early_fv: got %b want %b", frame_valid, 1'b0); end
    tick(1);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv_edge: got %b want %b", frame_valid, 1'b1); end
    total++; if (value !== 32'h21) begin bad++; $display("FAIL basic_value: got %h want %h", value, 32'h21); end
    tick(1);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_pulse: got %b want %b", frame_valid, 1'b0); end
    tick(6);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL basic_fv_count: got %0d want %0d", fv_cnt - fv0, 1); end
    total++; if (blank !== 8'h00) begin bad++; $display("FAIL basic_blank: got %h want %h", blank, 8'h00); end
    total++; if (dp !== 8'h00) begin bad++; $display("FAIL basic_dp: got %h want %h", dp, 8'h00); end
  endtask

  task automatic test_short_hold();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    for (int k = 0; k < 3; k++) begin
      drive(8'hFE, 7'h79, 1'b1, 3);
      drive(8'hFD, 7'h24, 1'b1, 3);
    end
    drive(8'hFF, 7'h7F, 1'b1, 6);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL short_fv: got %0d want %0d", fv_cnt - fv0, 0); end
    // Slot 1 alone must not complete a frame if nothing was captured before
    drive(8'hFD, 7'h24, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL short_seen: got %0d want %0d", fv_cnt - fv0, 0); end
    total++; if (value !== 32'h0) begin bad++; $display("FAIL short_value: got %h want %h", value, 32'h0); end
  endtask

  task automatic test_blank_dp();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    drive(8'hFE, 7'h12, 1'b0, 6);
    drive(8'hFD, 7'h7F, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL bdp_fv: got %0d want %0d", fv_cnt - fv0, 1); end
    total++; if (value !== 32'h05) begin bad++; $display("FAIL bdp_value: got %h want %h", value, 32'h05); end
    total++; if (dp !== 8'h01) begin bad++; $display("FAIL bdp_dp: got %h want %h", dp, 8'h01); end
    total++; if (blank !== 8'h02) begin bad++; $display("FAIL bdp_blank: got %h want %h", blank, 8'h02); end
  endtask

  task automatic test_errors();
    int fv0, bp0, ma0;
    do_reset();
    fv0 = fv_cnt; bp0 = bp_cnt; ma0 = ma_cnt;
    drive(8'hFC, 7'h40, 1'b1, 8);
    total++; if (ma_cnt - ma0 !== 1) begin bad++; $display("FAIL err_multi: got %0d want %0d", ma_cnt - ma0, 1); end
    total++; if (bp_cnt - bp0 !== 0) begin bad++; $display("FAIL err_multi_nobad: got %0d want %0d", bp_cnt - bp0, 0); end
    drive(8'hFE, 7'h55, 1'b1, 8);
    total++; if (bp_cnt - bp0 !== 1) begin bad++; $display("FAIL err_bad: got %0d want %0d", bp_cnt - bp0, 1); end
    // Neither error may have marked slot 0 as seen
    drive(8'hFD, 7'h24, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL err_nocapture: got %0d want %0d", fv_cnt - fv0, 0); end
    drive(8'hFE, 7'h30, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL err_recover_fv: got %0d want %0d", fv_cnt - fv0, 1); end
    total++; if (value !== 32'h23) begin bad++; $display("FAIL err_recover_value: got %h want %h", value, 32'h23); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(49);
    total++; if (scan_stall !== 1'b0) begin bad++; $display("FAIL to_before: got %b want %b", scan_stall, 1'b0); end
    tick(1);
    total++; if (scan_stall !== 1'b1) begin bad++; $display("FAIL to_assert: got %b want %b", scan_stall, 1'b1); end
    tick(10);
    total++; if (scan_stall !== 1'b1) begin bad++; $display("FAIL to_hold: got %b want %b", scan_stall, 1'b1); end
    drive(8'hFE, 7'h79, 1'b1, 4);
    total++; if (scan_stall !== 1'b1) begin bad++; $display("FAIL to_precap: got %b want %b", scan_stall, 1'b1); end
    tick(1);
    total++; if (scan_stall !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want %b", scan_stall, 1'b0); end
  endtask

  task automatic test_reset_midframe();
    int fv0;
    do_reset();
    drive(8'hFE, 7'h79, 1'b1, 6);
    drive(8'hFD, 7'h24, 1'b1, 8);
    total++; if (value !== 32'h21) begin bad++; $display("FAIL rmid_first: got %h want %h", value, 32'h21); end
    drive(8'hFE, 7'h40, 1'b1, 6);
    do_reset();
    fv0 = fv_cnt;
    total++; if (value !== 32'h0) begin bad++; $display("FAIL rmid_value: got %h want %h", value, 32'h0); end
    drive(8'hFD, 7'h24, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL rmid_nofv: got %0d want %0d", fv_cnt - fv0, 0); end
    drive(8'hFE, 7'h06, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL rmid_fv: got %0d want %0d", fv_cnt - fv0, 1); end
    total++; if (value !== 32'h2E) begin bad++; $display("FAIL rmid_recap: got %h want %h", value, 32'h2E); end
  endtask

  task automatic test_overwrite();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    drive(8'hFE, 7'h79, 1'b1, 6);
    drive(8'hFE, 7'h12, 1'b1, 6);
    drive(8'hFD, 7'h24, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL ovr_fv: got %0d want %0d", fv_cnt - fv0, 1); end
    total++; if (value !== 32'h25) begin bad++; $display("FAIL ovr_value: got %h want %h", value, 32'h25); end
  endtask

  task automatic test_back_to_back();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    drive(8'hFE, 7'h79, 1'b1, 6);
    drive(8'hFD, 7'h24, 1'b1, 6);
    drive(8'hFE, 7'h19, 1'b1, 6);
    // Unmasked slot 2 is captured but must never appear in the value
    drive(8'hFB, 7'h00, 1'b0, 6);
    drive(8'hFD, 7'h30, 1'b1, 8);
    total++; if (fv_cnt - fv0 !== 2) begin bad++; $display("FAIL b2b_fv: got %0d want %0d", fv_cnt - fv0, 2); end
    total++; if (value !== 32'h34) begin bad++; $display("FAIL b2b_value: got %h want %h", value, 32'h34); end
    total++; if (dp !== 8'h00) begin bad++; $display("FAIL b2b_dp_masked: got %h want %h", dp, 8'h00); end
  endtask

  initial begin
    rst  = 1'b1;
    AN   = 8'hFF;
    sseg = 7'h7F;
    DP   = 1'b1;
    test_reset();
    test_basic_frame();
    test_short_hold();
    test_blank_dp();
    test_errors();
    test_timeout();
    test_reset_midframe();
    test_overwrite();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
